// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants, types and the trellis predecessor rule.
// Both the ACS stage and the traceback use tb_pred, so they follow the same state convention.
package viterbi_pkg;
  localparam int SW = 3;
  localparam int DW = 8;
  localparam int AW = 10;

  typedef logic [SW-1:0] state_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} tb_fsm_e;

  // The state shifts left, and the decision bit for the current state fills the LSB.
  function automatic state_t tb_pred(state_t s, logic [DW-1:0] d);
    return {s[SW-2:0], d[s]};
  endfunction
endpackage

// File: rtl/viterbi_traceback.sv
// Walks survivor decisions backwards one step per cycle.
// Writes the decoded bits into the display memory in forward time order.
module viterbi_traceback
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  addr_t         start_addr,
  input  state_t        start_state,
  input  addr_t         tb_len,
  input  addr_t         out_base,
  output addr_t         mem_addr,
  input  logic [DW-1:0] mem_d_o,
  output logic          disp_wr,
  output addr_t         disp_addr,
  output logic          disp_d,
  output logic          busy,
  output logic          done,
  output state_t        final_state
);

  tb_fsm_e fsm_q, fsm_d;
  state_t  st_q, st_d;
  addr_t   cnt_q, cnt_d;
  addr_t   mem_addr_q, mem_addr_d;
  addr_t   wptr_q, wptr_d;
  logic    disp_wr_q, disp_wr_d;
  addr_t   disp_addr_q, disp_addr_d;
  logic    disp_d_q, disp_d_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  state_t  final_q, final_d;

  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    wptr_d      = wptr_q;
    disp_wr_d   = 1'b0;
    disp_addr_d = disp_addr_q;
    disp_d_d    = disp_d_q;
    done_d      = 1'b0;
    final_d     = final_q;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d       = start_state;
          cnt_d      = tb_len;
          mem_addr_d = start_addr;
          // Bits come out newest-first, so the write pointer starts at the top of the window.
          wptr_d     = out_base + tb_len - addr_t'(1);
          fsm_d      = (tb_len == '0) ? DONE : PRIME;
        end
      end
      PRIME: begin
        mem_addr_d = mem_addr_q - addr_t'(1);
        fsm_d      = RUN;
      end
      RUN: begin
        disp_wr_d   = 1'b1;
        disp_d_d    = st_q[SW-1];
        disp_addr_d = wptr_q;
        st_d        = tb_pred(st_q, mem_d_o);
        wptr_d      = wptr_q - addr_t'(1);
        mem_addr_d  = mem_addr_q - addr_t'(1);
        cnt_d       = cnt_q - addr_t'(1);
        if (cnt_q == addr_t'(1)) fsm_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        final_d = st_q;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      wptr_q      <= '0;
      disp_wr_q   <= 1'b0;
      disp_addr_q <= '0;
      disp_d_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      final_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      wptr_q      <= wptr_d;
      disp_wr_q   <= disp_wr_d;
      disp_addr_q <= disp_addr_d;
      disp_d_q    <= disp_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      final_q     <= final_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign disp_wr     = disp_wr_q;
  assign disp_addr   = disp_addr_q;
  assign disp_d      = disp_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_state = final_q;

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Traceback stage of the Viterbi decoder. It sits directly downstream of the 8x1024 survivor-decision memory. The ACS stage writes one 8-bit decision word per trellis step into that memory.
- On a start pulse, it walks the trellis backwards from a given address and state. It reads one decision word per cycle and recovers one decoded bit per step.
- It writes the decoded bits, in forward time order, into the 1x1024 display memory.

Parameters:
- SW, 3, state width in bits (8 states).
- DW, 8, decision word width; must equal 2**SW.
- AW, 10, address width of both memories (1024 entries).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a traceback; ignored unless idle
- start_addr  in  AW  address of the newest decision word to trace from
- start_state  in  SW  trellis state at the newest step
- tb_len  in  AW  number of steps to trace; 0 is allowed
- out_base  in  AW  display-memory address for the oldest decoded bit
- mem_addr  out  AW  read address to the decision memory (registered)
- mem_d_o  in  DW  decision word; valid one cycle after mem_addr is sampled
- disp_wr  out  1  write enable to the display memory
- disp_addr  out  AW  display-memory write address
- disp_d  out  1  decoded bit
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when a traceback completes
- final_state  out  SW  state reached after the oldest step; held until the next start

Behaviour:
- Reset: FSM goes to IDLE. mem_addr, disp_addr, disp_d, disp_wr, busy, done and final_state all clear to 0.
- Reset mid-traceback aborts immediately; no further disp_wr is issued.
- Trellis convention:
  - Forward transition: s_t = {u_t, s_{t-1}[SW-1:1]}.
  - Decoded bit at step t: u_t = s_t[SW-1].
  - Predecessor: s_{t-1} = {s_t[SW-2:0], d[s_t]}, where d is the decision word at address t.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE:
  - On start, latch the state register <= start_state, cnt <= tb_len, mem_addr <= start_addr, wptr <= out_base + tb_len - 1 (mod 2**AW).
  - If tb_len == 0, go to DONE; otherwise go to PRIME.
- PRIME: first read is in flight. Set mem_addr <= mem_addr - 1 and go to RUN.
- RUN, each cycle, with mem_d_o holding the word for the current step:
  - disp_wr <= 1, disp_d <= state[SW-1], disp_addr <= wptr.
  - state <= {state[SW-2:0], mem_d_o[state]}.
  - wptr <= wptr - 1, mem_addr <= mem_addr - 1, cnt <= cnt - 1.
  - When cnt == 1, go to DONE instead of staying in RUN.
- DONE:
  - disp_wr stays high for this one cycle only, registering the last write.
  - done pulses, final_state <= state, then return to IDLE.
- Throughput: one step per cycle.
- Latency:
  - First disp_wr is asserted 3 cycles after the start edge.
  - The last disp_wr is at start + 2 + tb_len cycles.
  - done asserts in the cycle after the last disp_wr goes low.
  - With tb_len = 0, done asserts 2 cycles after start and there are no writes.
- Address arithmetic: all address arithmetic is modulo 2**AW. Reads wrap 0 -> 1023; display writes wrap likewise.
- Reads past the last needed word (one extra read, issued in the final RUN cycle) are harmless and their data is ignored.
- start while busy is ignored. A start coincident with rst is ignored.
- disp_wr is never high in IDLE or PRIME.

Decomposition:
- Package viterbi_pkg holds:
  - constants SW, DW, AW;
  - typedef state_t (logic [SW-1:0]);
  - typedef addr_t (logic [AW-1:0]);
  - enum tb_fsm_e {IDLE, PRIME, RUN, DONE}.
- Also in the package: function tb_pred(state_t s, logic [DW-1:0] d) returning the predecessor state, so the ACS and the bench share one convention.
- No sub-module; the block is a single FSM plus datapath.

Test Plan:
- Decision memory all zeros; start_state=3'b101, start_addr=5, tb_len=4, out_base=0 -> display bits at addresses 0..3 = 0,1,0,1; final_state=3'b000; mem_addr sequence 5,4,3,2.
- Decision memory all ones; start_state=3'b000, start_addr=20, tb_len=4, out_base=100 -> bits at 100..103 = 1,0,0,0 (traced order 0,0,0,1); final_state=3'b111.
- Wrap: start_addr=1, tb_len=4 -> mem_addr sequence 1,0,1023,1022. With out_base=1022, writes go to addresses 1,0,1023,1022.
- tb_len=0 -> done pulses 2 cycles after start; disp_wr never asserts; busy high for exactly 1 cycle.
- start re-asserted during RUN, and rst asserted mid-RUN -> the second start has no effect; after rst all outputs are 0 next cycle, with no further disp_wr.
- Random decision memory, 200 random traceback jobs -> disp contents match a reference model built on tb_pred; first disp_wr is at start+3.
